// File: rtl/rom_load_ctrl.sv
// Cartridge download controller: routes ioctl bytes into ROM, decodes the file
// extension into mapper/SuperChip settings and sequences the console core reset.
module rom_load_ctrl #(
   parameter int POR_CYCLES    = 2000000,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [31:0] ioctl_file_ext,
   input  logic [1:0]  sc_mode,
   input  logic        user_reset,
   output logic        rom_we,
   output logic [15:0] rom_waddr,
   output logic [7:0]  rom_wdata,
   output logic [16:0] rom_size,
   output logic [3:0]  force_bs,
   output logic        sc,
   output logic        core_reset,
   output logic        loaded
);

   typedef enum logic [1:0] {POR, LOAD, SETTLE, RUN} state_t;

   localparam logic [31:0] POR_LAST    = 32'(POR_CYCLES - 1);
   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

   state_t      state;
   logic [31:0] cnt;
   logic        dl_prev;
   logic        dl_rise;
   logic        wr_in_rom;
   logic [23:0] ext;
   logic [3:0]  bs_dec;
   logic        sc_dec;

   assign dl_rise   = ioctl_download & ~dl_prev;
   assign wr_in_rom = (ioctl_addr[24:16] == 9'd0);

   // Three-letter extensions arrive right-aligned; a trailing "S" shifts the dot up a byte.
   always_comb begin
      ext    = (ioctl_file_ext[23:16] == ".") ? ioctl_file_ext[23:0] : ioctl_file_ext[31:8];
      bs_dec = 4'd0;
      case (ext)
         ".F8":   bs_dec = 4'd1;
         ".F6":   bs_dec = 4'd2;
         ".FE":   bs_dec = 4'd3;
         ".E0":   bs_dec = 4'd4;
         ".3F":   bs_dec = 4'd5;
         ".F4":   bs_dec = 4'd6;
         ".P2":   bs_dec = 4'd7;
         ".FA":   bs_dec = 4'd8;
         ".CV":   bs_dec = 4'd9;
         default: bs_dec = 4'd0;
      endcase
      case (sc_mode)
         2'b00:   sc_dec = (ioctl_file_ext[7:0] == "S");
         2'b01:   sc_dec = 1'b0;
         default: sc_dec = 1'b1;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state      <= POR;
         cnt        <= 32'd0;
         dl_prev    <= 1'b0;
         rom_we     <= 1'b0;
         rom_waddr  <= 16'd0;
         rom_wdata  <= 8'd0;
         rom_size   <= 17'd0;
         force_bs   <= 4'd0;
         sc         <= 1'b0;
         core_reset <= 1'b1;
         loaded     <= 1'b0;
      end else begin
         dl_prev <= ioctl_download;
         rom_we  <= 1'b0;
         if (dl_rise && state != LOAD) begin
            state      <= LOAD;
            cnt        <= 32'd0;
            rom_size   <= 17'd0;
            force_bs   <= bs_dec;
            sc         <= sc_dec;
            core_reset <= 1'b1;
            loaded     <= 1'b0;
         end else begin
            case (state)
               POR: begin
                  core_reset <= 1'b1;
                  loaded     <= 1'b0;
                  if (cnt == POR_LAST) begin
                     state      <= RUN;
                     core_reset <= user_reset;
                     loaded     <= (rom_size != 17'd0);
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               LOAD: begin
                  core_reset <= 1'b1;
                  if (ioctl_wr) begin
                     if (wr_in_rom) begin
                        rom_we    <= 1'b1;
                        rom_waddr <= ioctl_addr[15:0];
                        rom_wdata <= ioctl_dout;
                     end
                     if (rom_size != 17'h1FFFF)
                        rom_size <= rom_size + 17'd1;
                  end
                  if (!ioctl_download) begin
                     state <= SETTLE;
                     cnt   <= 32'd0;
                  end
               end
               SETTLE: begin
                  core_reset <= 1'b1;
                  if (cnt == SETTLE_LAST) begin
                     state      <= RUN;
                     core_reset <= user_reset;
                     loaded     <= (rom_size != 17'd0);
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               RUN: begin
                  core_reset <= user_reset;
                  loaded     <= (rom_size != 17'd0);
               end
               default: state <= POR;
            endcase
         end
      end
   end

endmodule
